// File: rtl/aemb_iwb_cache_if.sv
`default_nettype none
// =============================================================================
// Module   : aemb_iwb_cache_if
// Brief    : CPU fetch port and refill memory port of the instruction cache.
// Revision : 1.0
// =============================================================================
interface aemb_iwb_cache_if #(
    parameter int IW = 32
);
    logic          iwb_stb_i;
    logic [IW-1:2] iwb_adr_i;
    logic [31:0]   iwb_dat_o;
    logic          iwb_ack_o;
    logic          mem_stb_o;
    logic [IW-1:2] mem_adr_o;
    logic [31:0]   mem_dat_i;
    logic          mem_ack_i;

    // The cache is the slave of the CPU fetch path.
    modport slave (
        input  iwb_stb_i, iwb_adr_i, mem_dat_i, mem_ack_i,
        output iwb_dat_o, iwb_ack_o, mem_stb_o, mem_adr_o
    );

    modport master (
        output iwb_stb_i, iwb_adr_i, mem_dat_i, mem_ack_i,
        input  iwb_dat_o, iwb_ack_o, mem_stb_o, mem_adr_o
    );
endinterface
`default_nettype wire

// File: rtl/aemb_iwb_cache.sv
`default_nettype none
// =============================================================================
// Module   : aemb_iwb_cache
// Brief    : Direct-mapped instruction cache with burst line refill and flush.
// Revision : 1.0
// =============================================================================
module aemb_iwb_cache #(
    parameter int IW = 32,
    parameter int AW = 8,
    parameter int LW = 2
) (
    input  wire             sys_clk_i,
    input  wire             sys_rst_i,
    input  wire             ich_fls_i,
    output logic            ich_bsy_o,
    aemb_iwb_cache_if.slave bus
);
    localparam int c_TAG_W = IW - AW - LW - 2;
    localparam int c_LINES = 1 << AW;
    localparam int c_WORDS = 1 << (AW + LW);
    localparam int c_CNT_W = (LW > 0) ? LW : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST   = c_CNT_W'((1 << LW) - 1);
    localparam logic [AW-1:0]      c_SWEEP_LAST = '1;

    typedef enum logic [1:0] {
        INVAL = 2'd0,
        IDLE  = 2'd1,
        FILL  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_stateNext;

    logic [31:0]        r_data [c_WORDS];
    logic [c_TAG_W-1:0] r_tag  [c_LINES];
    logic [c_LINES-1:0] r_valid;
    logic [AW-1:0]      r_sweep;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_memStb;
    logic [IW-1:2]      r_memAdr;
    logic               r_flsPend;

    logic [AW+LW-1:0]   w_cpuWord;
    logic [AW-1:0]      w_cpuIdx;
    logic [c_TAG_W-1:0] w_cpuTag;
    logic [AW+LW-1:0]   w_fillWord;
    logic [AW-1:0]      w_fillIdx;
    logic [c_TAG_W-1:0] w_fillTag;
    logic [IW-1:2]      w_missBase;
    logic [IW-1:2]      w_memAdrInc;
    logic               w_hit;
    logic               w_ack;
    logic               w_miss;
    logic               w_fillAck;
    logic               w_fillLast;

    generate
        if (AW + LW + 2 >= IW) begin : g_badParams
            $error("aemb_iwb_cache: AW+LW+2 must be smaller than IW");
        end
        // The refill address only walks the offset bits so a burst stays inside its line.
        if (LW > 0) begin : g_multiWord
            assign w_missBase  = {bus.iwb_adr_i[IW-1:LW+2], {LW{1'b0}}};
            assign w_memAdrInc = {r_memAdr[IW-1:LW+2], r_memAdr[LW+1:2] + LW'(1)};
        end else begin : g_singleWord
            assign w_missBase  = bus.iwb_adr_i;
            assign w_memAdrInc = r_memAdr;
        end
    endgenerate

    assign w_cpuWord  = bus.iwb_adr_i[AW+LW+1:2];
    assign w_cpuIdx   = bus.iwb_adr_i[AW+LW+1:LW+2];
    assign w_cpuTag   = bus.iwb_adr_i[IW-1:AW+LW+2];
    assign w_fillWord = r_memAdr[AW+LW+1:2];
    assign w_fillIdx  = r_memAdr[AW+LW+1:LW+2];
    assign w_fillTag  = r_memAdr[IW-1:AW+LW+2];

    assign w_hit      = bus.iwb_stb_i & r_valid[w_cpuIdx] & (r_tag[w_cpuIdx] == w_cpuTag);
    assign w_miss     = (r_state == IDLE) & ~ich_fls_i & bus.iwb_stb_i & ~w_hit;
    assign w_fillAck  = (r_state == FILL) & bus.mem_ack_i;
    assign w_fillLast = (r_cnt == c_CNT_LAST);

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_state <= INVAL;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_ack       = 1'b0;
        case (r_state)
            INVAL: begin
                if (!ich_fls_i && r_sweep == c_SWEEP_LAST) begin
                    w_stateNext = IDLE;
                end
            end
            IDLE: begin
                // A flush outranks both a hit and a miss in the same cycle.
                if (ich_fls_i) begin
                    w_stateNext = INVAL;
                end else if (w_hit) begin
                    w_ack = 1'b1;
                end else if (bus.iwb_stb_i) begin
                    w_stateNext = FILL;
                end
            end
            FILL: begin
                if (bus.mem_ack_i && w_fillLast) begin
                    w_stateNext = (r_flsPend || ich_fls_i) ? INVAL : IDLE;
                end
            end
            default: w_stateNext = INVAL;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_sweep   <= '0;
            r_memStb  <= 1'b0;
            r_memAdr  <= '0;
            r_cnt     <= '0;
            r_flsPend <= 1'b0;
        end else begin
            case (r_state)
                INVAL: r_sweep <= ich_fls_i ? '0 : r_sweep + 1'b1;
                IDLE: begin
                    if (ich_fls_i) begin
                        r_sweep <= '0;
                    end else if (w_miss) begin
                        r_memStb <= 1'b1;
                        r_memAdr <= w_missBase;
                        r_cnt    <= '0;
                    end
                end
                FILL: begin
                    r_flsPend <= r_flsPend | ich_fls_i;
                    if (bus.mem_ack_i) begin
                        r_memAdr <= w_memAdrInc;
                        r_cnt    <= r_cnt + 1'b1;
                        if (w_fillLast) begin
                            r_memStb  <= 1'b0;
                            r_cnt     <= '0;
                            r_flsPend <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage writes are suppressed during reset so an abandoned burst leaves no trace.
    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_i) begin
            if (r_state == INVAL) begin
                r_valid[r_sweep] <= 1'b0;
            end
            if (w_miss) begin
                r_valid[w_cpuIdx] <= 1'b0;
            end
            if (w_fillAck) begin
                r_data[w_fillWord] <= bus.mem_dat_i;
                if (w_fillLast) begin
                    r_tag[w_fillIdx]   <= w_fillTag;
                    r_valid[w_fillIdx] <= 1'b1;
                end
            end
        end
    end

    assign bus.iwb_ack_o = w_ack;
    assign bus.iwb_dat_o = r_data[w_cpuWord];
    assign bus.mem_stb_o = r_memStb;
    assign bus.mem_adr_o = r_memAdr;
    assign ich_bsy_o     = (r_state == INVAL);

endmodule
`default_nettype wire

// File: tb/tb_aemb_iwb_cache.sv
`default_nettype none
// =============================================================================
// Module   : tb_aemb_iwb_cache
// Brief    : Self-checking bench for aemb_iwb_cache against a line-level model.
// Revision : 1.0
// =============================================================================
module tb_aemb_iwb_cache;
    localparam int AW    = 8;
    localparam int LW    = 2;
    localparam int NLINE = 1 << AW;
    localparam int NWORD = 1 << LW;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic fls  = 1'b0;
    logic fls2 = 1'b0;
    logic bsy;
    logic bsy2;
    int   checks = 0;
    int   errors = 0;
    int   memLat = 0;
    logic [29:0] memLog[$];
    logic [13:0] memLog2[$];
    bit          mValid[NLINE];
    logic [31:0] mTag[NLINE];

    always #5 clk = ~clk;

    aemb_iwb_cache_if #(.IW(32)) bus();
    aemb_iwb_cache_if #(.IW(16)) bus2();

    aemb_iwb_cache #(.IW(32), .AW(AW), .LW(LW)) dut (
        .sys_clk_i (clk),
        .sys_rst_i (rst),
        .ich_fls_i (fls),
        .ich_bsy_o (bsy),
        .bus       (bus.slave)
    );

    aemb_iwb_cache #(.IW(16), .AW(4), .LW(0)) dut2 (
        .sys_clk_i (clk),
        .sys_rst_i (rst),
        .ich_fls_i (fls2),
        .ich_bsy_o (bsy2),
        .bus       (bus2.slave)
    );

    function automatic logic [31:0] memWord(input logic [31:0] wordAdr);
        return (wordAdr * 32'h9E37_79B1) ^ 32'hC3A5_1F07;
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Memory for the main cache: each word costs memLat idle cycles plus one ack cycle.
    initial begin : memResponder
        int latCnt;
        latCnt = 0;
        bus.mem_ack_i = 1'b0;
        bus.mem_dat_i = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_stb_o === 1'b1 && !rst) begin
                if (latCnt < memLat) begin
                    latCnt++;
                    bus.mem_ack_i = 1'b0;
                end else begin
                    latCnt = 0;
                    bus.mem_ack_i = 1'b1;
                    bus.mem_dat_i = memWord({2'b0, bus.mem_adr_o});
                    memLog.push_back(bus.mem_adr_o);
                end
            end else begin
                latCnt = 0;
                bus.mem_ack_i = 1'b0;
            end
        end
    end

    initial begin : memResponder2
        bus2.mem_ack_i = 1'b0;
        bus2.mem_dat_i = '0;
        forever begin
            @(negedge clk);
            if (bus2.mem_stb_o === 1'b1 && !rst) begin
                bus2.mem_ack_i = 1'b1;
                bus2.mem_dat_i = memWord({18'b0, bus2.mem_adr_o});
                memLog2.push_back(bus2.mem_adr_o);
            end else begin
                bus2.mem_ack_i = 1'b0;
            end
        end
    end

    task automatic mFlush();
        foreach (mValid[i]) mValid[i] = 1'b0;
    endtask

    // Called at a sample point; counts sampled cycles while the sweep is busy.
    task automatic waitSweep(output int cyc, output bit ackSeen, output bit stbSeen);
        cyc = 0; ackSeen = 1'b0; stbSeen = 1'b0;
        while (bsy === 1'b1 && cyc < 2000) begin
            cyc++;
            if (bus.iwb_ack_o === 1'b1) ackSeen = 1'b1;
            if (bus.mem_stb_o === 1'b1) stbSeen = 1'b1;
            @(negedge clk); #1;
        end
    endtask

    task automatic pulseFlush();
        @(negedge clk); fls = 1'b1;
        @(negedge clk); fls = 1'b0;
        #1;
    endtask

    task automatic fetch(input logic [31:0] a);
        int          idx;
        int          waits;
        int          expWaits;
        bit          expHit;
        logic [31:0] wadr;
        logic [31:0] tag;
        logic [31:0] base;
        wadr     = a >> 2;
        idx      = int'((wadr / NWORD) % NLINE);
        tag      = wadr / (NWORD * NLINE);
        base     = wadr - (wadr % NWORD);
        expHit   = mValid[idx] && (mTag[idx] == tag);
        expWaits = expHit ? 0 : NWORD * (memLat + 1) + 1;
        memLog.delete();
        @(negedge clk);
        bus.iwb_stb_i = 1'b1;
        bus.iwb_adr_i = wadr[29:0];
        #1;
        waits = 0;
        while (bus.iwb_ack_o !== 1'b1 && waits < 200) begin
            @(negedge clk); #1;
            waits++;
        end
        check("fetch_lat", 32'(waits), 32'(expWaits));
        check("fetch_dat", bus.iwb_dat_o, memWord(wadr));
        bus.iwb_stb_i = 1'b0;
        if (expHit) begin
            check("hit_memstb", 32'(bus.mem_stb_o), 32'd0);
        end else begin
            check("fill_len", 32'(memLog.size()), 32'(NWORD));
            foreach (memLog[k]) check("fill_adr", 32'(memLog[k]), base + 32'(k));
        end
        mValid[idx] = 1'b1;
        mTag[idx]   = tag;
    endtask

    task automatic fetch2(input logic [15:0] a, input bit expHit);
        int waits;
        memLog2.delete();
        @(negedge clk);
        bus2.iwb_stb_i = 1'b1;
        bus2.iwb_adr_i = a[15:2];
        #1;
        waits = 0;
        while (bus2.iwb_ack_o !== 1'b1 && waits < 50) begin
            @(negedge clk); #1;
            waits++;
        end
        check("b2_lat", 32'(waits), expHit ? 32'd0 : 32'd2);
        check("b2_dat", bus2.iwb_dat_o, memWord({18'b0, a[15:2]}));
        bus2.iwb_stb_i = 1'b0;
        if (!expHit) begin
            check("b2_len", 32'(memLog2.size()), 32'd1);
            if (memLog2.size() > 0) check("b2_adr", 32'(memLog2[0]), {18'b0, a[15:2]});
        end
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : stimulus
        int  cyc;
        int  acks;
        int  n;
        bit  ackSeen;
        bit  stbSeen;
        bit  early;
        bit  flsDone;
        logic [31:0] a;

        bus.iwb_stb_i  = 1'b0;
        bus.iwb_adr_i  = '0;
        bus2.iwb_stb_i = 1'b0;
        bus2.iwb_adr_i = '0;

        // One reset edge, then a fetch held high across the whole sweep.
        @(negedge clk);
        rst = 1'b0;
        bus.iwb_stb_i = 1'b1;
        bus.iwb_adr_i = 30'h40;
        #1;
        check("rst_bsy", 32'(bsy), 32'd1);
        check("rst_memadr", 32'(bus.mem_adr_o), 32'd0);
        waitSweep(cyc, ackSeen, stbSeen);
        bus.iwb_stb_i = 1'b0;
        check("rst_sweep_len", 32'(cyc), 32'(NLINE));
        check("rst_sweep_ack", 32'(ackSeen), 32'd0);
        check("rst_sweep_stb", 32'(stbSeen), 32'd0);

        // Cold line fill, then the remaining words of the line hit.
        memLat = 0;
        fetch(32'h100);
        fetch(32'h104);
        fetch(32'h108);
        fetch(32'h10C);

        // Same index, different tag evicts the line.
        fetch(32'h100 + (32'd1 << (AW + LW + 2)));
        fetch(32'h100);
        fetch(32'h104);

        // Flush on the second ack of a fill: burst completes, then sweep.
        memLog.delete();
        @(negedge clk);
        bus.iwb_stb_i = 1'b1;
        bus.iwb_adr_i = 30'(32'h3200 >> 2);
        #1;
        acks = 0; n = 0; ackSeen = 1'b0; flsDone = 1'b0;
        while (n < 60) begin
            if (bus.mem_ack_i === 1'b1) acks++;
            if (bus.iwb_ack_o === 1'b1) ackSeen = 1'b1;
            if (acks == 2 && !flsDone) begin
                fls = 1'b1;
                bus.iwb_stb_i = 1'b0;
                flsDone = 1'b1;
            end else begin
                fls = 1'b0;
            end
            if (bsy === 1'b1) break;
            @(negedge clk); #1;
            n++;
        end
        fls = 1'b0;
        check("fls_fill_len", 32'(memLog.size()), 32'(NWORD));
        check("fls_fill_ack", 32'(ackSeen), 32'd0);
        waitSweep(cyc, ackSeen, stbSeen);
        check("fls_sweep_len", 32'(cyc), 32'(NLINE));
        mFlush();
        fetch(32'h100);

        // Fetch strobe drops after the first refill ack on slow memory.
        memLat = 3;
        memLog.delete();
        @(negedge clk);
        bus.iwb_stb_i = 1'b1;
        bus.iwb_adr_i = 30'(32'h4300 >> 2);
        #1;
        acks = 0; n = 0; early = 1'b0; ackSeen = 1'b0;
        while (n < 100) begin
            if (bus.mem_ack_i === 1'b1) begin
                acks++;
                bus.iwb_stb_i = 1'b0;
            end
            if (bus.iwb_ack_o === 1'b1) ackSeen = 1'b1;
            if (n > 0 && bus.mem_stb_o !== 1'b1) begin
                if (acks < NWORD) early = 1'b1;
                break;
            end
            @(negedge clk); #1;
            n++;
        end
        check("drop_acks", 32'(acks), 32'(NWORD));
        check("drop_early", 32'(early), 32'd0);
        check("drop_iwback", 32'(ackSeen), 32'd0);
        mValid[(32'h4300 >> 4) % NLINE] = 1'b1;
        mTag[(32'h4300 >> 4) % NLINE]   = 32'h4300 >> (AW + LW + 2);
        fetch(32'h430C);

        // Reset in the middle of a burst.
        memLat = 0;
        @(negedge clk);
        bus.iwb_stb_i = 1'b1;
        bus.iwb_adr_i = 30'(32'h5400 >> 2);
        #1;
        acks = 0; n = 0;
        while (acks < 2 && n < 40) begin
            if (bus.mem_ack_i === 1'b1) acks++;
            if (acks < 2) begin
                @(negedge clk); #1;
                n++;
            end
        end
        rst = 1'b1;
        bus.iwb_stb_i = 1'b0;
        @(negedge clk); #1;
        check("rstfill_memstb", 32'(bus.mem_stb_o), 32'd0);
        check("rstfill_bsy", 32'(bsy), 32'd1);
        rst = 1'b0;
        waitSweep(cyc, ackSeen, stbSeen);
        check("rstfill_sweep", 32'(cyc), 32'(NLINE));
        mFlush();

        // A second flush during the sweep restarts it from index zero.
        pulseFlush();
        cyc = 0;
        while (bsy === 1'b1 && cyc < 2000) begin
            cyc++;
            fls = (cyc == 100);
            @(negedge clk); #1;
        end
        fls = 1'b0;
        check("restart_sweep", 32'(cyc), 32'(100 + NLINE));

        // Randomised traffic over a few tags and indices with random flushes.
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                pulseFlush();
                waitSweep(cyc, ackSeen, stbSeen);
                check("rnd_sweep", 32'(cyc), 32'(NLINE));
                mFlush();
            end
            memLat = int'($urandom_range(0, 2));
            a = (32'($urandom_range(0, 3)) << (AW + LW + 2))
              | (32'($urandom_range(0, 7)) << (LW + 2))
              | (32'($urandom_range(0, NWORD - 1)) << 2);
            fetch(a);
        end

        // Narrow configuration: single-word lines at the top of the address space.
        check("b2_idle", 32'(bsy2), 32'd0);
        fetch2(16'hFFFC, 1'b0);
        fetch2(16'hFFFC, 1'b1);
        fetch2(16'h7FFC, 1'b0);
        fetch2(16'hFFFC, 1'b0);
        fetch2(16'hFFFC, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/aemb_iwb_cache.md
Name: aemb_iwb_cache

Overview:
- Parametrised direct-mapped instruction cache between the core's instruction Wishbone port (iwb_*) and external instruction memory.
- Configurable in address width, number of lines and line length (burst fill).
- Adds zero-wait-state hits, multi-word line refill and software/system flush, none of which exist on the bare core fetch path.
- Instantiated beside the core top level; the core's iwb_stb_o/iwb_adr_o/iwb_dat_i/iwb_ack_i connect to the CPU-side ports.

Parameters:
- IW, 32, instruction address width; byte address, word-aligned, bits [IW-1:2] used.
- AW, 8, log2 of number of cache lines (index bits).
- LW, 2, log2 of words per line (0 = single-word lines).
- Constraint: AW+LW+2 < IW; elaboration error otherwise.

Ports:
- sys_clk_i  in  1  sole clock, rising edge.
- sys_rst_i  in  1  reset; synchronous, active-high.
- iwb_stb_i  in  1  CPU fetch strobe.
- iwb_adr_i  in  IW-2 [IW-1:2]  CPU word address.
- iwb_dat_o  out  32  fetched instruction.
- iwb_ack_o  out  1  fetch complete.
- ich_fls_i  in  1  flush request, single-cycle pulse.
- ich_bsy_o  out  1  invalidation sweep in progress.
- mem_stb_o  out  1  refill strobe to memory.
- mem_adr_o  out  IW-2 [IW-1:2]  refill word address.
- mem_dat_i  in  32  refill data.
- mem_ack_i  in  1  refill word acknowledge.

Behaviour:
- Address split: off = adr[LW+1:2]; idx = adr[AW+LW+1:LW+2]; tag = adr[IW-1:AW+LW+2].
- Storage: data array 2^(AW+LW) x 32; tag array 2^AW x (IW-AW-LW-2); valid bit per line. All asynchronous read.
- Reset (sys_rst_i=1 at an edge): state<=INVAL, sweep counter<=0, mem_stb_o<=0, mem_adr_o<=0, fill counter<=0, pending-flush<=0. iwb_ack_o=0 and ich_bsy_o=1 while in INVAL. Reset mid-FILL abandons the burst immediately; mem_stb_o drops next edge.
- States:
  - INVAL: clear valid[sweep], increment sweep; after 2^AW cycles go IDLE. iwb_ack_o=0 throughout.
  - IDLE: hit = iwb_stb_i & valid[idx] & tag match. iwb_ack_o=hit, combinational, same cycle; iwb_dat_o=data[idx,off]. A miss with iwb_stb_i=1 registers the line base, clears valid[idx], sets mem_stb_o=1 and mem_adr_o={tag,idx,0}, then goes FILL.
  - FILL: mem_stb_o held 1. Each cycle with mem_ack_i=1 writes mem_dat_i to data[idx,cnt], increments cnt and mem_adr_o. On the last ack (cnt=2^LW-1) writes tag, sets valid, drops mem_stb_o next edge, clears cnt and goes IDLE (or INVAL if flush pending). iwb_ack_o=0 in FILL.
- Refilled word is delivered by the IDLE hit on the following cycle. Miss latency from stb to ack with zero-wait memory = 2^LW+1 cycles.
- iwb_stb_i deassertion or address change during FILL: the burst always completes; the new address is evaluated in IDLE.
- ich_fls_i in IDLE: goes INVAL; flush takes priority over a simultaneous miss; no ack that cycle. ich_fls_i during FILL: latched as pending, serviced after the line completes. ich_fls_i during INVAL: restarts sweep at 0.
- iwb_dat_o is don't-care when iwb_ack_o=0.
- mem_adr_o wraps within the line only; it never crosses a line boundary.

Test Plan:
- Reset 1 cycle, AW=8 -> ich_bsy_o=1 for exactly 256 cycles, iwb_ack_o=0 for those cycles, mem_stb_o=0.
- LW=2, cold fetch at 0x100, zero-wait memory -> mem_adr_o word addresses 0x40,0x41,0x42,0x43 on consecutive cycles, iwb_ack_o on cycle 5 with the word at 0x40; then fetches 0x104/0x108/0x10C ack same cycle with mem_stb_o=0.
- Conflict: fill 0x100, then fetch 0x100+(1<<(AW+LW+2)) -> miss and refill; re-fetch 0x100 -> miss again.
- ich_fls_i pulsed on the 2nd ack of a 4-word fill -> fill completes all 4 words, then 256-cycle sweep, then 0x100 misses.
- iwb_stb_i dropped after 1st ack of a fill, memory with 3-cycle ack latency -> mem_stb_o stays high until 4th ack; no iwb_ack_o issued.
- LW=0, AW=4, IW=16, fetch at top address 0xFFFC -> single-word fill at mem_adr_o=0x3FFF; hit next cycle; tag compare correct at width boundary.
